// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: RISC-V load/store func3
// codes, FSM state encoding and access-size classification.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_NONE = 2'd3
  } size_e;

  // Low two func3 bits give the access width for both loads and stores.
  function automatic size_e f3_size(input logic [2:0] func3);
    case (func3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      2'b10:   return SZ_WORD;
      default: return SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Lane selection, byte-enable generation, load extension and error detection
// for one load/store request against a little-endian 32-bit word memory.
module mem_lane_align
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  size_e       size;
  logic        legal;
  logic        misalign;
  logic        oor;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    size     = f3_size(func3);
    legal    = we ? (func3 inside {F3_SB, F3_SH, F3_SW})
                  : (func3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    misalign = ((size == SZ_HALF) && addr[0]) ||
               ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    oor      = {2'b00, addr[31:2]} >= DEPTH_L;
    err      = !legal || misalign || oor;

    case (addr[1:0])
      2'b00:   rbyte = rword[7:0];
      2'b01:   rbyte = rword[15:8];
      2'b10:   rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
    rhalf = addr[1] ? rword[31:16] : rword[15:0];

    be    = 4'b0000;
    wlane = 32'h0;
    rdata = 32'h0;
    if (!err) begin
      // func3[2] marks the unsigned load variants
      case (size)
        SZ_BYTE: begin
          be    = 4'b0001 << addr[1:0];
          wlane = {4{wdata[7:0]}};
          rdata = func3[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
        end
        SZ_HALF: begin
          be    = addr[1] ? 4'b1100 : 4'b0011;
          wlane = {2{wdata[15:0]}};
          rdata = func3[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
        end
        SZ_WORD: begin
          be    = 4'b1111;
          wlane = wdata;
          rdata = rword;
        end
        default: ;
      endcase
      if (we) begin
        rdata = 32'h0;
      end else begin
        be    = 4'b0000;
        wlane = 32'h0;
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with fixed response latency.
//   state   | meaning
//   ST_IDLE | ready for a request (req_ready = 1)
//   ST_BUSY | latency down-counter running
//   ST_RESP | response held until rsp_ready
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          enter_resp;
  logic          cur_we;
  logic [2:0]    cur_func3;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] word_idx;
  logic [31:0]   rword;
  logic          la_err;
  logic [3:0]    la_be;
  logic [31:0]   la_wlane;
  logic [31:0]   la_rdata;

  // With LATENCY = 1 the commit edge is the accept edge, so the live request
  // must feed the lane logic while idle rather than the captured copy.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_we    = req_we;
      cur_func3 = req_func3;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end else begin
      cur_we    = we_q;
      cur_func3 = func3_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    word_idx = cur_addr[2 +: AW];
    rword    = mem_q[word_idx];
  end

  mem_lane_align #(.DEPTH_WORDS(DEPTH_WORDS)) u_lane (
    .we    (cur_we),
    .func3 (cur_func3),
    .addr  (cur_addr),
    .wdata (cur_wdata),
    .rword (rword),
    .err   (la_err),
    .be    (la_be),
    .wlane (la_wlane),
    .rdata (la_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          func3_d = req_func3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      rsp_rdata_d = la_rdata;
      rsp_err_d   = la_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      func3_q     <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_we) begin
      for (int i = 0; i < 4; i++) begin
        if (la_be[i]) begin
          mem_q[word_idx][8*i +: 8] <= la_wlane[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized checks of data_mem_responder against a byte-array
// reference model of the load/store rules.
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem_b [DEPTH*4];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, sizes 1/2/4, natural alignment rules.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int n;
    bit legal;
    bit uns;
    logic [31:0] v;
    n = 0; legal = 1'b1; uns = 1'b0;
    case (f3)
      3'b000: n = 1;
      3'b001: n = 2;
      3'b010: n = 4;
      3'b100: begin n = 1; uns = 1'b1; legal = !we; end
      3'b101: begin n = 2; uns = 1'b1; legal = !we; end
      default: legal = 1'b0;
    endcase
    if (legal && (addr % n) != 0) legal = 1'b0;
    if ((addr >> 2) >= DEPTH) legal = 1'b0;
    err = !legal;
    rd  = 32'h0;
    if (legal) begin
      if (we) begin
        for (int k = 0; k < n; k++) mem_b[addr + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v = v | (32'(mem_b[addr + k]) << (8 * k));
        if (n < 4 && !uns && v[8*n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        rd = v;
      end
    end
  endtask

  task automatic garbage();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b010;
    req_addr  = 32'($urandom_range(0, DEPTH - 1)) << 2;
    req_wdata = $urandom();
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int stall, input bit hold_valid,
                      input string tag, output logic [31:0] obs_rd, output logic obs_err);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          k;
    model(we, f3, addr, wd, exp_err, exp_rd);
    @(negedge clk);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (hold_valid) garbage();
      else req_valid = 1'b0;
    end while (!rsp_valid && k < 40);
    check({tag, "_latency"}, 32'(k), 32'(LAT));
    obs_rd  = rsp_rdata;
    obs_err = rsp_err;
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (hold_valid) garbage();
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;

    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_func3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    for (int w = 0; w < DEPTH; w++)
      xact(1'b1, 3'b010, 32'(w) << 2, $urandom(), 0, 1'b0, "init", r, e);

    xact(1'b1, 3'b010, 32'h10, 32'h12345678, 0, 1'b0, "sw10", r, e);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, "lw10", r, e);
    check("lw10_const", r, 32'h12345678);

    xact(1'b1, 3'b000, 32'h11, 32'h000000AB, 0, 1'b0, "sb11", r, e);
    xact(1'b0, 3'b000, 32'h11, 32'h0, 0, 1'b0, "lb11", r, e);
    check("lb11_const", r, 32'hFFFFFFAB);
    xact(1'b0, 3'b100, 32'h11, 32'h0, 0, 1'b0, "lbu11", r, e);
    check("lbu11_const", r, 32'h000000AB);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, "lw10b", r, e);
    check("lw10b_const", r, 32'h1234AB78);

    xact(1'b0, 3'b001, 32'h13, 32'h0, 0, 1'b0, "lh13", r, e);
    check("lh13_err_const", 32'(e), 32'd1);
    xact(1'b1, 3'b010, 32'h0E, 32'hCAFEF00D, 0, 1'b0, "sw0e", r, e);
    check("sw0e_err_const", 32'(e), 32'd1);
    xact(1'b0, 3'b010, 32'h0C, 32'h0, 0, 1'b0, "lw0c", r, e);

    xact(1'b0, 3'b011, 32'h0, 32'h0, 0, 1'b0, "ld011", r, e);
    check("ld011_err_const", 32'(e), 32'd1);
    xact(1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 0, 1'b0, "lwoor", r, e);
    check("lwoor_err_const", 32'(e), 32'd1);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 3, 1'b1, "holdvalid", r, e);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 5, 1'b0, "stall5", r, e);

    @(negedge clk);
    check("rstmid_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_func3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_rdata", rsp_rdata, 32'h0);
    check("rstmid_err", 32'(rsp_err), 32'd0);
    rst = 1'b0;
    xact(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0, "lw20", r, e);

    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = $urandom();
      else a = 32'($urandom_range(0, DEPTH * 4 + 7));
      xact(we, f3, a, $urandom(), $urandom_range(0, 2), $urandom_range(0, 3) == 0,
           "rnd", r, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit storage words.
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_func3  input  3  RISC-V load/store func3 width/sign code.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  core accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request rejected (misaligned, illegal func3, out of range).

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request when req_valid && req_ready, capturing we/func3/addr/wdata in that cycle.
REQ-017 SHALL, on acceptance, go to RESP directly when LATENCY = 1, else to BUSY with a down-counter loaded with LATENCY-2, leaving BUSY when the counter is 0.
REQ-018 SHALL assert rsp_valid exactly LATENCY cycles after the accepting edge and hold rsp_valid, rsp_rdata, rsp_err stable until rsp_valid && rsp_ready.
REQ-019 SHALL return to IDLE on the response-handshake edge; a new request is accepted no earlier than the following cycle (max one outstanding).
REQ-020 SHALL decode loads: 000 lb sign-ext, 001 lh sign-ext, 010 lw, 100 lbu zero-ext, 101 lhu zero-ext; all other load codes are errors.
REQ-021 SHALL decode stores: 000 sb, 001 sh, 010 sw; all other store codes are errors.
REQ-022 SHALL select byte lane addr[1:0] for byte ops, halfword lane addr[1] for halfword ops; little-endian.
REQ-023 SHALL flag misalignment: halfword with addr[0] = 1, word with addr[1:0] != 0.
REQ-024 SHALL flag out-of-range when addr[31:2] >= DEPTH_WORDS.
REQ-025 SHALL, on any error, set rsp_err = 1, rsp_rdata = 0, and leave memory unmodified.
REQ-026 SHALL commit a legal store with byte-enable masking on the edge entering RESP; unselected bytes unchanged.
REQ-027 SHALL read load data on the edge entering RESP, so a load after a store to the same address returns the stored value.
REQ-028 SHALL ignore req_valid and all request inputs while in BUSY or RESP.

Reset
REQ-029 SHALL, when rst = 1 at a clock edge, enter IDLE with rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0; req_ready = 1 from the next cycle.
REQ-030 SHALL drop an in-flight request on reset mid-operation; a store not yet committed does not modify memory.
REQ-031 SHALL NOT reset storage contents; reset has priority over all other events.

Structure
REQ-032 SHALL take func3 encodings (LB/LH/LW/LBU/LHU, SB/SH/SW) and the FSM state encoding from the shared core package.
REQ-033 SHALL place lane selection, byte-enable generation, extension and error detection in one combinational sub-module, mem_lane_align.

Verification
REQ-034 sw 0x12345678 @0x10, then lw @0x10 (LATENCY = 2) -> rsp_valid exactly 2 cycles after each acceptance, rdata = 0x12345678, err = 0.
REQ-035 sb 0xAB @0x11 over word 0x12345678, then lb @0x11 -> 0xFFFFFFAB; lbu @0x11 -> 0x000000AB; lw @0x10 -> 0x1234AB78.
REQ-036 lh @0x13 and sw @0x0E -> rsp_err = 1, rdata = 0; lw @0x0C afterwards returns its prior value unchanged.
REQ-037 load with func3 = 011 and lw @ (DEPTH_WORDS*4) -> rsp_err = 1; req_valid held during BUSY/RESP is not accepted.
REQ-038 hold rsp_ready = 0 for 5 cycles -> rsp_valid/rdata stable, req_ready = 0; then rsp_ready = 1 -> IDLE next cycle.
REQ-039 assert rst in BUSY of sw 0xDEADBEEF @0x20 -> outputs 0 next cycle, lw @0x20 returns the old value.
